// File: rtl/viterbi_frame_sched.sv
// ---------------------------------------------------------------------------
// viterbi_frame_sched
//
// Frame-level scheduler for the Viterbi decoder datapath (branch metric,
// add-compare-select, survivor memory, traceback). One frame is in flight at
// a time. Symbols are accepted over a valid/ready handshake and walk through
// a two-stage enable pipeline (en_brch -> en_add -> en_mem). Each accepted
// symbol produces exactly one survivor-memory write. Traceback then reads the
// survivor memory from the newest address down to 0, one decoded bit per
// downstream handshake.
//
// Parameters
//   FRAME_LEN  coded symbols per frame (>= 2); also the traceback length
//   ADDR_W     survivor-memory address width, 2**ADDR_W >= FRAME_LEN
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a frame (sampled only while idle)
//   sym_valid  coded symbol available from the source
//   sym_ready  scheduler accepts a symbol this cycle
//   en_brch    branch-metric stage enable (same cycle as acceptance)
//   en_add     ACS stage enable (en_brch delayed one cycle)
//   en_mem     survivor-memory write enable (en_add delayed one cycle)
//   en_tbck    traceback enable
//   wr_addr    survivor write address, valid while en_mem=1
//   rd_addr    survivor read address, valid while en_tbck=1
//   dec_valid  decoded bit available from traceback
//   dec_ready  downstream consumes the decoded bit
//   busy       high whenever the scheduler is not idle
//   done       one-cycle pulse when a frame completes
//
// Optional feature, enabled by defining VITERBI_SCHED_ABORT_EN:
//   abort      request to drop the current frame (ignored while idle)
//   aborted    one-cycle pulse in the cycle the abort is taken
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; all enables low
// LOAD  | accepting FRAME_LEN symbols, pipeline enables follow acceptance
// FLUSH | no more symbols; waiting for the last writes to drain
// TBCK  | traceback, one decoded bit per dec_valid & dec_ready
// DONE  | one-cycle completion pulse, then back to IDLE
// ---------------------------------------------------------------------------
module viterbi_frame_sched #(
    parameter int FRAME_LEN = 12,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic              en_brch,
    output logic              en_add,
    output logic              en_mem,
    output logic              en_tbck,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic              busy,
    output logic              done
`ifdef VITERBI_SCHED_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_TBCK  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // sym_cnt is one bit wider than the address so it can hold FRAME_LEN
    // itself when 2**ADDR_W == FRAME_LEN.
    localparam logic [ADDR_W:0]   FRAME_CNT = (ADDR_W+1)'(FRAME_LEN);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [ADDR_W:0] sym_cnt;
    logic            abort_req;
    logic            accept;
    logic            last_sym;
    logic            pipe_empty;
    logic            dec_hs;
    logic            frame_start;

`ifdef VITERBI_SCHED_ABORT_EN
    assign abort_req = abort && (state != S_IDLE);
    assign aborted   = abort_req;
`else
    assign abort_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshakes and status decode
    // ------------------------------------------------------------------
    // sym_ready is withheld during an abort so no symbol is acknowledged
    // that the datapath will never see written.
    assign sym_ready   = (state == S_LOAD) && (sym_cnt < FRAME_CNT) && !abort_req;
    assign accept      = sym_valid && sym_ready;
    assign en_brch     = accept;
    assign last_sym    = accept && (sym_cnt == LAST_CNT);
    assign pipe_empty  = !en_add && !en_mem;
    assign frame_start = (state == S_IDLE) && start;

    assign en_tbck     = (state == S_TBCK);
    assign dec_valid   = (state == S_TBCK);
    assign dec_hs      = dec_valid && dec_ready;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    // ------------------------------------------------------------------
    // Next-state logic; abort overrides every other transition.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (abort_req) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start)      state_nxt = S_LOAD;
                S_LOAD:  if (last_sym)   state_nxt = S_FLUSH;
                S_FLUSH: if (pipe_empty) state_nxt = S_TBCK;
                S_TBCK:  if (dec_hs && (rd_addr == '0)) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Enable pipeline. Bubbles in sym_valid simply travel through as
    // zeros; outside LOAD/FLUSH the stages are held clear so a partial
    // frame can never leak a write into the next one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_add <= 1'b0;
            en_mem <= 1'b0;
        end else if (((state == S_LOAD) || (state == S_FLUSH)) && !abort_req) begin
            en_add <= accept;
            en_mem <= en_add;
        end else begin
            en_add <= 1'b0;
            en_mem <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Symbol counter and survivor write address. Both restart only when
    // a new frame begins; wr_addr advances after each write so it reads
    // 0..FRAME_LEN-1 across the FRAME_LEN writes of a frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt <= '0;
        end else if (frame_start) begin
            sym_cnt <= '0;
        end else if (accept) begin
            sym_cnt <= sym_cnt + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
        end else if (frame_start) begin
            wr_addr <= '0;
        end else if (en_mem && !abort_req) begin
            wr_addr <= wr_addr + ADDR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Traceback read address: loaded with the newest write on entry to
    // TBCK, steps down only when the decoded bit is taken. The handshake
    // at address 0 ends the frame, so it never decrements past 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (abort_req) begin
            rd_addr <= '0;
        end else begin
            case (state)
                S_FLUSH: if (pipe_empty) rd_addr <= LAST_ADDR;
                S_TBCK:  if (dec_hs && (rd_addr != '0)) rd_addr <= rd_addr - ADDR_W'(1);
                S_DONE:  rd_addr <= '0;
                default: rd_addr <= rd_addr;
            endcase
        end
    end

endmodule
